// File: rtl/dmem_arbiter_pkg.sv
// Shared processor package: data-memory map constants, arbiter geometry
// defaults and the arbiter FSM state encoding.
// No ports; imported by the dmem_arbiter interface and modules.
package dmem_arbiter_pkg;

  // Processor memory map. Data memory is everything whose upper address
  // bits above DMEMADDRBITS are zero; the I/O page sits at the top.
  localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] IO_BASE   = 32'hFFFF_F000;

  localparam int DBITS_DEFAULT        = 32;
  localparam int DMEMADDRBITS_DEFAULT = 16;
  localparam int DMEMWORDBITS_DEFAULT = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Port id to one-hot per-port strobe vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-requester data-memory bus plus the memory-side strobes.
// Per port N (0,1): reqN/weN/addrN/wdataN from the requester,
// gntN/doneN/errN/rdataN back to it.
// Memory side: mem_en/mem_we/mem_addr/mem_wdata to the RAM, mem_rdata back.
// master: requesters and RAM model; slave: the arbiter.
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS        = DBITS_DEFAULT,
  parameter int DMEMADDRBITS = DMEMADDRBITS_DEFAULT,
  parameter int DMEMWORDBITS = DMEMWORDBITS_DEFAULT
);
  logic                                   req0, req1;
  logic                                   we0, we1;
  logic [DBITS-1:0]                       addr0, addr1;
  logic [DBITS-1:0]                       wdata0, wdata1;
  logic                                   gnt0, gnt1;
  logic                                   done0, done1;
  logic                                   err0, err1;
  logic [DBITS-1:0]                       rdata0, rdata1;
  logic                                   mem_en, mem_we;
  logic [DMEMADDRBITS-DMEMWORDBITS-1:0]   mem_addr;
  logic [DBITS-1:0]                       mem_wdata;
  logic [DBITS-1:0]                       mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker.
// Ports: clk, reset (async, active-high), req[1:0] requests,
// take (winner accepted this cycle), win[1:0] one-hot winner (0 if no req).
// Holds the last-served flag; reset makes port 1 "last served" so port 0
// wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);
  logic last1;

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last1 ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last1 <= 1'b1;
    else if (take) last1 <= win[1];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory between two requesters.
// Ports: clk, reset (async, active-high), bus (dmem_arbiter_if.slave):
// per-port req/we/addr/wdata in, gnt/done/err/rdata out; memory strobes out,
// mem_rdata in (valid the cycle after a read strobe).
//
// state      | meaning
// -----------+-------------------------------------------------------
// ARB_IDLE   | waiting; arbitrates and latches the winner's request
// ARB_ACCESS | gnt pulse; memory strobe if address is in data memory
// ARB_RESP   | done pulse; read data / err returned to the winner
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS        = DBITS_DEFAULT,
  parameter int DMEMADDRBITS = DMEMADDRBITS_DEFAULT,
  parameter int DMEMWORDBITS = DMEMWORDBITS_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int WABITS = DMEMADDRBITS - DMEMWORDBITS;

  arb_state_e        state, state_nxt;
  logic [1:0]        win;
  logic              take;
  logic              port_w, we_w, in_rng_w;
  logic [DBITS-1:0]  addr_w, wdata_w;
  logic              port_q, we_q, in_rng_q;
  logic [1:0]        gnt_q, done_q, err_q;
  logic [1:0]        gnt_nxt, done_nxt, err_nxt;
  logic              en_q, mwe_q, en_nxt, mwe_nxt;
  logic [WABITS-1:0] maddr_q;
  logic [DBITS-1:0]  mwdata_q;
  logic              unused_offset;

  rr_arb2 u_rr (
    .clk  (clk),
    .reset(reset),
    .req  ({bus.req1, bus.req0}),
    .take (take),
    .win  (win)
  );

  assign port_w   = win[1];
  assign we_w     = port_w ? bus.we1    : bus.we0;
  assign addr_w   = port_w ? bus.addr1  : bus.addr0;
  assign wdata_w  = port_w ? bus.wdata1 : bus.wdata0;
  assign in_rng_w = (addr_w[DBITS-1:DMEMADDRBITS] == '0);
  // Byte offset within the word is not used by a word-wide memory.
  assign unused_offset = ^addr_w[DMEMWORDBITS-1:0];

  // Outputs are computed one state ahead and registered, so the strobes
  // appear in the cycle of the state they belong to.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    gnt_nxt   = 2'b00;
    done_nxt  = 2'b00;
    err_nxt   = 2'b00;
    en_nxt    = 1'b0;
    mwe_nxt   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (bus.req0 || bus.req1) begin
          take      = 1'b1;
          state_nxt = ARB_ACCESS;
          gnt_nxt   = win;
          en_nxt    = in_rng_w;
          mwe_nxt   = in_rng_w & we_w;
        end
      end
      ARB_ACCESS: begin
        state_nxt = ARB_RESP;
        done_nxt  = port_onehot(port_q);
        err_nxt   = port_onehot(port_q) & {2{~in_rng_q}};
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      in_rng_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      gnt_q  <= gnt_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
      en_q   <= en_nxt;
      mwe_q  <= mwe_nxt;
      if (take) begin
        port_q   <= port_w;
        we_q     <= we_w;
        in_rng_q <= in_rng_w;
        maddr_q  <= addr_w[DMEMADDRBITS-1:DMEMWORDBITS];
        mwdata_q <= wdata_w;
      end
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.done0     = done_q[0];
  assign bus.done1     = done_q[1];
  assign bus.err0      = err_q[0];
  assign bus.err1      = err_q[1];
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

  // The RAM registers its read data, so it is only available during RESP;
  // pass it through gated by the done pulse rather than registering again.
  assign bus.rdata0 = (done_q[0] && !err_q[0] && !we_q) ? bus.mem_rdata : '0;
  assign bus.rdata1 = (done_q[1] && !err_q[1] && !we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int DB = 32;
  localparam int AB = 16;
  localparam int WB = 2;
  localparam int WA = AB - WB;
  localparam int NW = 1 << WA;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DBITS(DB), .DMEMADDRBITS(AB), .DMEMWORDBITS(WB)) bus ();

  dmem_arbiter #(.DBITS(DB), .DMEMADDRBITS(AB), .DMEMWORDBITS(WB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] pat(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // RAM seen by the DUT: synchronous read, write on strobe.
  logic [31:0] pmem [NW];
  bit pmem_ready = 1'b0;
  always @(posedge clk) begin
    if (!pmem_ready) begin
      for (int i = 0; i < NW; i++) pmem[i] <= pat(i);
      pmem_ready <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) pmem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= pmem[bus.mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    gnt;
    logic [1:0]    done;
    logic [1:0]    err;
    logic [31:0]   rd0;
    logic [31:0]   rd1;
    logic          en;
    logic          we;
    logic [WA-1:0] maddr;
    logic [31:0]   mwd;
  } exp_t;

  exp_t        exp_q [4];
  logic [31:0] rmem [NW];
  bit          rmem_ready = 1'b0;
  int          cyc = 0;
  int          busy_until = 0;
  int          last_served = 1;
  bit          pend_v = 1'b0;
  int          pend_edge, pend_p, m_p, m_slot;
  logic        pend_we;
  logic [31:0] pend_addr, pend_wd;

  always @(posedge clk or posedge reset) begin
    if (!rmem_ready) begin
      for (int i = 0; i < NW; i++) rmem[i] = pat(i);
      rmem_ready = 1'b1;
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) exp_q[i] = '0;
      last_served = 1;
      busy_until  = 0;
      pend_v      = 1'b0;
    end else begin
      cyc++;
      exp_q[(cyc + 3) % 4] = '0;
      if (pend_v && cyc == pend_edge + 1) begin
        m_slot = cyc % 4;
        exp_q[m_slot].done[pend_p] = 1'b1;
        if (pend_addr[31:16] != 16'h0)
          exp_q[m_slot].err[pend_p] = 1'b1;
        else if (pend_we)
          rmem[pend_addr[15:2]] = pend_wd;
        else if (pend_p == 0)
          exp_q[m_slot].rd0 = rmem[pend_addr[15:2]];
        else
          exp_q[m_slot].rd1 = rmem[pend_addr[15:2]];
        pend_v = 1'b0;
      end
      if (cyc >= busy_until && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) m_p = (last_served == 1) ? 0 : 1;
        else                      m_p = bus.req1 ? 1 : 0;
        last_served = m_p;
        busy_until  = cyc + 3;
        pend_p    = m_p;
        pend_edge = cyc;
        pend_v    = 1'b1;
        pend_addr = (m_p == 1) ? bus.addr1  : bus.addr0;
        pend_we   = (m_p == 1) ? bus.we1    : bus.we0;
        pend_wd   = (m_p == 1) ? bus.wdata1 : bus.wdata0;
        m_slot = cyc % 4;
        exp_q[m_slot].gnt[m_p] = 1'b1;
        exp_q[m_slot].en    = (pend_addr[31:16] == 16'h0);
        exp_q[m_slot].we    = (pend_addr[31:16] == 16'h0) && pend_we;
        exp_q[m_slot].maddr = pend_addr[15:2];
        exp_q[m_slot].mwd   = pend_wd;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  exp_t ce;
  always @(negedge clk) begin
    if (chk_on) begin
      ce = exp_q[cyc % 4];
      checks++;
      if ({bus.gnt1, bus.gnt0} !== ce.gnt || {bus.done1, bus.done0} !== ce.done ||
          {bus.err1, bus.err0} !== ce.err || bus.rdata0 !== ce.rd0 || bus.rdata1 !== ce.rd1 ||
          bus.mem_en !== ce.en || bus.mem_we !== ce.we) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t got gnt=%b done=%b err=%b rd0=%h rd1=%h en=%b we=%b want gnt=%b done=%b err=%b rd0=%h rd1=%h en=%b we=%b",
                 $time, {bus.gnt1, bus.gnt0}, {bus.done1, bus.done0}, {bus.err1, bus.err0},
                 bus.rdata0, bus.rdata1, bus.mem_en, bus.mem_we,
                 ce.gnt, ce.done, ce.err, ce.rd0, ce.rd1, ce.en, ce.we);
      end
      if (|ce.gnt) begin
        checks++;
        if (bus.mem_addr !== ce.maddr || bus.mem_wdata !== ce.mwd) begin
          failures++;
          $display("FAIL access_addr t=%0t got addr=%h wdata=%h want addr=%h wdata=%h",
                   $time, bus.mem_addr, bus.mem_wdata, ce.maddr, ce.mwd);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    else        begin bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  function automatic logic port_gnt(input int p);
    return (p == 0) ? bus.gnt0 : bus.gnt1;
  endfunction

  function automatic logic port_done(input int p);
    return (p == 0) ? bus.done0 : bus.done1;
  endfunction

  // One transaction on port p; returns what was seen on the memory side
  // during the grant cycle and on the response side during done.
  task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit pulse, output logic s_en, output logic s_we,
                     output logic [31:0] s_addr, output logic s_err,
                     output logic [31:0] s_rd, output bit ok);
    int n;
    ok = 1'b0; s_en = 1'b0; s_we = 1'b0; s_addr = '0; s_err = 1'b0; s_rd = '0;
    @(posedge clk); #1;
    drive(p, 1'b1, w, a, d);
    n = 0;
    do begin @(negedge clk); n++; end while (!port_gnt(p) && n < 10);
    if (!port_gnt(p)) begin
      expire("txn_gnt");
      drop_req(p);
      return;
    end
    s_en   = bus.mem_en;
    s_we   = bus.mem_we;
    s_addr = 32'(bus.mem_addr);
    if (pulse) begin @(posedge clk); #1; drop_req(p); end
    @(negedge clk);
    if (!port_done(p)) begin
      expire("txn_done");
    end else begin
      ok    = 1'b1;
      s_err = (p == 0) ? bus.err0 : bus.err1;
      s_rd  = (p == 0) ? bus.rdata0 : bus.rdata1;
    end
    @(posedge clk); #1;
    drop_req(p);
  endtask

  // ---------------- stimulus ----------------
  logic        t_en, t_we, t_err;
  logic [31:0] t_addr, t_rd, old_word, ra;
  bit          t_ok;
  bit          act [2];
  int          n, cnt, ng, nd;
  int          gseq [8];
  int          dtime [8];

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) exp_q[i] = '0;
    #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({bus.gnt1, bus.gnt0, bus.done1, bus.done0,
                           bus.err1, bus.err0, bus.mem_en, bus.mem_we}), 32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_rdata0", bus.rdata0, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);
    reset = 1'b0;

    // port 0 write, then port 1 reads it back
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, t_en, t_we, t_addr, t_err, t_rd, t_ok);
    check("wr_en", 32'(t_en), 32'h1);
    check("wr_we", 32'(t_we), 32'h1);
    check("wr_addr", t_addr, 32'h0004);
    check("wr_done", 32'(t_ok), 32'h1);
    check("wr_err", 32'(t_err), 32'h0);

    txn(1, 1'b0, 32'h0000_0010, 32'h1234_5678, 1'b0, t_en, t_we, t_addr, t_err, t_rd, t_ok);
    check("rd_we", 32'(t_we), 32'h0);
    check("rd_en", 32'(t_en), 32'h1);
    check("rd_done", 32'(t_ok), 32'h1);
    check("rd_data", t_rd, 32'hDEAD_BEEF);

    // out-of-range read
    txn(0, 1'b0, 32'hFFFF_F020, 32'h0, 1'b0, t_en, t_we, t_addr, t_err, t_rd, t_ok);
    check("oor_en", 32'(t_en), 32'h0);
    check("oor_done", 32'(t_ok), 32'h1);
    check("oor_err", 32'(t_err), 32'h1);
    check("oor_rdata", t_rd, 32'h0);

    // one-cycle request pulse on port 1
    txn(1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, t_en, t_we, t_addr, t_err, t_rd, t_ok);
    check("pulse_done", 32'(t_ok), 32'h1);
    check("pulse_rdata", t_rd, 32'hDEAD_BEEF);
    cnt = 0;
    repeat (6) begin @(negedge clk); if (bus.gnt1) cnt++; end
    check("pulse_no_second", cnt, 0);

    // both ports requesting continuously from reset
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0014, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    ng = 0; nd = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.gnt0 && ng < 8) begin gseq[ng] = 0; ng++; end
      if (bus.gnt1 && ng < 8) begin gseq[ng] = 1; ng++; end
      if ((bus.done0 || bus.done1) && nd < 8) begin dtime[nd] = t; nd++; end
    end
    check("alt_grants_seen", 32'(ng >= 4), 32'h1);
    if (ng >= 4) begin
      check("alt_g0", gseq[0], 0);
      check("alt_g1", gseq[1], 1);
      check("alt_g2", gseq[2], 0);
      check("alt_g3", gseq[3], 1);
    end
    check("alt_dones_seen", 32'(nd >= 4), 32'h1);
    if (nd >= 4) for (int i = 1; i < 4; i++) check("alt_done_gap", dtime[i] - dtime[i-1], 3);
    @(posedge clk); #1;
    drop_req(0); drop_req(1);

    // reset during ACCESS of a port 1 write
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    old_word = pmem[8];
    drive(1, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.gnt1 && n < 10);
    if (!bus.gnt1) expire("rst_acc_gnt");
    reset = 1'b1;
    drop_req(1);
    #1;
    check("rst_acc_ctrl", 32'({bus.gnt1, bus.gnt0, bus.done1, bus.done0,
                               bus.err1, bus.err0, bus.mem_en, bus.mem_we}), 32'h0);
    check("rst_acc_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_acc_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    repeat (5) begin @(negedge clk); if (bus.done1) cnt++; end
    check("rst_acc_no_done", cnt, 0);
    check("rst_acc_no_write", pmem[8], old_word);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.gnt0 || bus.gnt1) && n < 10);
    if (!(bus.gnt0 || bus.gnt1)) expire("rst_first_gnt");
    else check("rst_first_winner", 32'({bus.gnt1, bus.gnt0}), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    drop_req(0); drop_req(1);
    repeat (4) @(posedge clk);

    // randomized traffic with occasional resets
    act[0] = 1'b0; act[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        drop_req(0); drop_req(1);
        act[0] = 1'b0; act[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        continue;
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          if (port_done(p)) begin
            drop_req(p);
            act[p] = 1'b0;
          end else if (port_gnt(p) && $urandom_range(0, 3) == 0) begin
            drop_req(p);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          ra = $urandom;
          if ($urandom_range(0, 9) == 0) ra[31:16] = ra[31:16] | 16'h0001;
          else begin ra[31:16] = 16'h0; ra[15:8] = 8'h0; end
          drive(p, 1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
          act[p] = 1'b1;
        end
      end
    end
    drop_req(0); drop_req(1);
    repeat (6) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DBITS, default 32, data and address width.
REQ-002 Parameter DMEMADDRBITS, default 16, byte-address bits decoded as data memory.
REQ-003 Parameter DMEMWORDBITS, default 2, byte-offset bits dropped to form the word address.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 reqN  input  1  (N=0,1) access request; held high by requester until doneN.
REQ-007 weN  input  1  1=write, 0=read; sampled at grant.
REQ-008 addrN  input  DBITS  byte address; sampled at grant.
REQ-009 wdataN  input  DBITS  write data; sampled at grant.
REQ-010 gntN  output  1  one-cycle pulse: port N request accepted.
REQ-011 doneN  output  1  one-cycle pulse: port N transaction complete.
REQ-012 errN  output  1  valid with doneN; address outside data memory.
REQ-013 rdataN  output  DBITS  read data; valid only while doneN=1 and errN=0.
REQ-014 mem_en  output  1  memory access strobe.
REQ-015 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  output  DMEMADDRBITS-DMEMWORDBITS  word address.
REQ-017 mem_wdata  output  DBITS  memory write data.
REQ-018 mem_rdata  input  DBITS  synchronous-read data, valid the cycle after a mem_en read.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; encoded in 2 bits.
REQ-020 IDLE: no request -> stay IDLE; any reqN -> ACCESS, latching winner's we/addr/wdata and port id.
REQ-021 Single requester: that port wins.
REQ-022 Both requesting: the port not served last wins (round-robin); the last-served flag updates on every grant.
REQ-023 ACCESS (exactly one cycle): gntN=1 for the winner; mem_en=1 only if latched addr[DBITS-1:DMEMADDRBITS]==0; mem_we=latched we; mem_addr=latched addr[DMEMADDRBITS-1:DMEMWORDBITS]; mem_wdata=latched wdata; -> RESP.
REQ-024 RESP (exactly one cycle): doneN=1 for the winner; rdataN=mem_rdata for in-range reads, 0 for writes and errors; errN=1 if out of range; -> IDLE.
REQ-025 Latency: req high at edge k (state IDLE) -> gnt during cycle k+1 -> done during cycle k+2; one transaction per 3 cycles maximum.
REQ-026 A request arriving in ACCESS or RESP waits; it is arbitrated in the next IDLE cycle.
REQ-027 reqN dropping after acceptance does not abort; the transaction completes and doneN still pulses.
REQ-028 Out-of-range access never asserts mem_en or mem_we.
REQ-029 gnt0/gnt1 never both high; done0/done1 never both high; all gnt/done/err outputs registered (no combinational path from req to outputs).
REQ-030 Non-winner outputs stay 0 throughout.

Reset
REQ-031 Reset forces state IDLE; all gnt, done, err, mem_en and mem_we to 0; rdata0/rdata1, mem_addr and mem_wdata to 0; last-served flag to port 1, so port 0 wins the first contention.
REQ-032 Reset mid-transaction aborts it with no done pulse and no further memory strobe; an in-flight write is not retried.

Structure
REQ-033 FSM state encodings and the DMEMADDRBITS/DMEMWORDBITS defaults belong in the shared processor package, alongside the existing memory-map constants.
REQ-034 One sub-module, rr_arb2: a 2-input round-robin picker holding the last-served flag and producing a one-hot winner.

Verification
REQ-035 Port 0 write addr=0x00000010, wdata=0xDEADBEEF -> gnt0 cycle 1, mem_en=1, mem_we=1, mem_addr=0x0004; done0 cycle 2, err0=0.
REQ-036 Port 1 read addr=0x00000010 after REQ-035 -> done1 with rdata1=0xDEADBEEF, mem_we=0.
REQ-037 Both ports request continuously from reset -> grants alternate 0,1,0,1; each done exactly 3 cycles apart.
REQ-038 Port 0 read addr=0xFFFFF020 -> done0 with err0=1, rdata0=0; mem_en stays 0.
REQ-039 Reset asserted during ACCESS of a port 1 write -> outputs 0 immediately, no done1; first contention after reset granted to port 0.
REQ-040 req1 pulsed for one cycle then dropped -> gnt1 and done1 still each pulse once; no second transaction.
